unload_store: RTL and testbench
===============================

UNLOAD_STORE -- requirements
Module: unload_store

Interface
REQ-001 Parameter N, default 400000, full-scale level; the drain starts here and the refill stops here.
REQ-002 Parameter CBITS, default 19, level width; SHALL satisfy 2^CBITS > N.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  consumer request for one unit, sampled each posedge.
REQ-006 grant  output  1  registered; high for one cycle per unit delivered.
REQ-007 level  output  CBITS  registered; current stored quantity.
REQ-008 mode  output  1  registered; 1 = DRAIN, 0 = REFILL.
REQ-009 sig  output  1  registered; empty indicator, high throughout REFILL.

Function
REQ-010 States: DRAIN (serves requests, level falls) and REFILL (ignores requests, level rises); the state is held in mode.
REQ-011 DRAIN with level == 0: next cycle mode=0, sig=1, grant=0, and level stays 0.
REQ-012 DRAIN with level > 0 and req=1: next cycle level=level-1 and grant=1.
REQ-013 DRAIN with level > 0 and req=0: next cycle level is unchanged and grant=0.
REQ-014 Grant latency SHALL be exactly one cycle: a req sampled at edge k produces grant high in the cycle after edge k.
REQ-015 Back-to-back req SHALL be granted every cycle until level reaches 0.
REQ-016 REFILL: grant=0 every cycle; req is ignored and not queued.
REQ-017 REFILL with level < N: next cycle level=min(level+STEP, N), where STEP=1 by default.
REQ-018 REFILL with level >= N: next cycle mode=1, sig=0, level=N, grant=0.
REQ-019 Level SHALL never leave [0, N]: no underflow below 0 and no overflow above N.
REQ-020 Mode change and a grant SHALL never occur on the same edge; the edge that reaches level 0 may grant, and the following edge switches mode.
REQ-021 sig SHALL be 0 whenever mode=1 after the cycle that enters DRAIN, and 1 whenever mode=0.
REQ-022 Liveness: with rst held low and req held high, sig SHALL rise within N+1 cycles, and mode SHALL return to 1 within a further N/STEP+1 cycles.

Reset
REQ-023 rst=1 at posedge: level=N, mode=1, sig=0, grant=0 on the next cycle.
REQ-024 rst SHALL take priority over every other input, including req and any mid-drain or mid-refill state.
REQ-025 The first cycle after rst deasserts SHALL behave as DRAIN with level=N.

Configuration
REQ-026 Macro UNLOAD_STORE_FAST_REFILL_EN defined: STEP=2, with level saturating at N on the final step; all other behaviour is unchanged.
REQ-027 Macro UNLOAD_STORE_FAST_REFILL_EN undefined: STEP=1.
REQ-028 The port list SHALL be identical in both builds.

Verification (bench overrides N=8, CBITS=4)
REQ-029 rst high 2 cycles, then low, req=0 -> level=8, mode=1, sig=0, grant=0, and level stays 8 for 20 cycles.
REQ-030 After reset, req held high -> grant high for 8 consecutive cycles while level steps 7,6,...,0; the next cycle gives mode=0, sig=1, grant=0.
REQ-031 In REFILL from level 0, req held high, macro off -> level steps 1..8 with grant=0 throughout; the next cycle gives mode=1, sig=0.
REQ-032 Same as REQ-031 with the macro on -> level steps 2,4,6,8; the next cycle gives mode=1, sig=0.
REQ-033 req pattern 1,0,1,1 from level 8 -> grant pattern 1,0,1,1 delayed by one cycle, and level ends at 5.
REQ-034 rst pulsed for 1 cycle during REFILL at level 3 -> next cycle level=8, mode=1, sig=0, grant=0.

Source files
------------

// File: rtl/unload_store.sv
// Unload/store controller: serves unit requests while draining from N to 0, then refills back to N.
// Build option UNLOAD_STORE_FAST_REFILL_EN doubles the refill step (STEP=2).
module unload_store #(
  parameter int N     = 400000,
  parameter int CBITS = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             grant,
  output logic [CBITS-1:0] level,
  output logic             mode,
  output logic             sig
);

`ifdef UNLOAD_STORE_FAST_REFILL_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  localparam logic MODE_REFILL = 1'b0;
  localparam logic MODE_DRAIN  = 1'b1;

  localparam logic [CBITS-1:0] LVL_FULL = CBITS'(N);

  // Sum is formed one bit wider so the last step cannot wrap before clamping to N.
  function automatic logic [CBITS-1:0] refill_sat(input logic [CBITS-1:0] lv);
    logic [CBITS:0] sum;
    sum = {1'b0, lv} + (CBITS+1)'(STEP);
    if (sum >= (CBITS+1)'(N))
      refill_sat = LVL_FULL;
    else
      refill_sat = sum[CBITS-1:0];
  endfunction

  // Output register stage: every port is driven directly from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= LVL_FULL;
      mode  <= MODE_DRAIN;
      sig   <= 1'b0;
      grant <= 1'b0;
    end else if (mode == MODE_DRAIN) begin
      if (level == '0) begin
        mode  <= MODE_REFILL;
        sig   <= 1'b1;
        grant <= 1'b0;
      end else if (req) begin
        level <= level - 1'b1;
        grant <= 1'b1;
      end else begin
        grant <= 1'b0;
      end
    end else begin
      grant <= 1'b0;
      if (level >= LVL_FULL) begin
        mode  <= MODE_DRAIN;
        sig   <= 1'b0;
        level <= LVL_FULL;
      end else begin
        level <= refill_sat(level);
      end
    end
  end

endmodule

// File: tb/tb_unload_store.sv
// Directed bench for unload_store with N=8, CBITS=4; expected values are hand-derived.
module tb_unload_store;
  localparam int N     = 8;
  localparam int CBITS = 4;
`ifdef UNLOAD_STORE_FAST_REFILL_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req;
  logic             grant;
  logic [CBITS-1:0] level;
  logic             mode;
  logic             sig;

  int pass_cnt  = 0;
  int total_cnt = 0;

  unload_store #(.N(N), .CBITS(CBITS)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .grant(grant),
    .level(level),
    .mode (mode),
    .sig  (sig)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int lv, input logic m,
                           input logic s, input logic g);
    check({tag, ".level"}, 32'(level), 32'(lv));
    check({tag, ".mode"},  32'(mode),  32'(m));
    check({tag, ".sig"},   32'(sig),   32'(s));
    check({tag, ".grant"}, 32'(grant), 32'(g));
  endtask

  initial begin
    int lv;
    rst = 1'b1;
    req = 1'b0;
    step();
    step();
    check_all("reset", 8, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step();
      check_all("idle", 8, 1'b1, 1'b0, 1'b0);
    end

    // Continuous request drains 8 units, one grant per cycle.
    req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_all("drain", 7 - i, 1'b1, 1'b0, 1'b1);
    end
    step();
    check_all("empty", 0, 1'b0, 1'b1, 1'b0);

    // Refill with req still high: requests are ignored.
    lv = 0;
    while (lv < N) begin
      lv = (lv + STEP > N) ? N : lv + STEP;
      step();
      check_all("refill", lv, 1'b0, 1'b1, 1'b0);
    end
    step();
    check_all("full", 8, 1'b1, 1'b0, 1'b0);

    // req 1,0,1,1 -> grant 1,0,1,1 one cycle later.
    req = 1'b1; step(); check_all("pat0", 7, 1'b1, 1'b0, 1'b1);
    req = 1'b0; step(); check_all("pat1", 7, 1'b1, 1'b0, 1'b0);
    req = 1'b1; step(); check_all("pat2", 6, 1'b1, 1'b0, 1'b1);
    req = 1'b1; step(); check_all("pat3", 5, 1'b1, 1'b0, 1'b1);

    // Drain the remaining 5, enter refill, climb part way.
    for (int i = 0; i < 5; i++) step();
    check("pre_empty.level", 32'(level), 32'd0);
    step();
    check("mid.mode", 32'(mode), 32'd0);
    lv = 0;
    for (int i = 0; i < ((STEP == 1) ? 3 : 2); i++) begin
      step();
      lv += STEP;
    end
    check_all("mid_refill", lv, 1'b0, 1'b1, 1'b0);

    // One-cycle reset mid-refill, with req high, wins over everything.
    rst = 1'b1;
    step();
    check_all("rst_mid", 8, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_all("post_rst", 7, 1'b1, 1'b0, 1'b1);
    req = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
